v_chunk_fifo: RTL and testbench
===============================

Name:
v_chunk_fifo

Overview:
- Chunk-granular buffer between vector ops in the mlops pipeline.
- Typical placement: directly downstream of v_leakyrelu, capturing each WorkingRegs-wide chunk it emits (wr_en driven by the producer's req_chunk_out).
- Serves the stored chunks to the next vector op on request (rd_en driven by the consumer's req_chunk_in).
- Exposes vec_ready, meaning at least one complete vector is buffered. This drives the consumer's in_data_ready.

Parameters:
- VecLength, 16, elements per vector.
- NBits, 8, bits per element (signed two's complement, passed through unchanged).
- WorkingRegs, 4, elements per chunk.
- DepthVecs, 2, buffer capacity in whole vectors.
- Derived: C = ceil(VecLength/WorkingRegs) chunks per vector; E = DepthVecs*C chunk entries.
- Derived: pointer width $clog2(E); count width $clog2(E+1).

Ports:
- clk_in, input, 1, clock; all state updates on the rising edge.
- rst_in, input, 1, reset, asynchronous, active-high.
- wr_en, input, 1, write one chunk this cycle.
- wr_data, input, [WorkingRegs-1:0][NBits-1:0] signed, chunk to write.
- rd_en, input, 1, read one chunk this cycle.
- rd_data, output, [WorkingRegs-1:0][NBits-1:0] signed, chunk read; registered.
- rd_valid, output, 1, rd_data holds a chunk popped on the previous cycle.
- vec_ready, output, 1, chunk count >= C.
- full, output, 1, chunk count == E.
- empty, output, 1, chunk count == 0.
- chunk_count, output, count width, number of stored chunks.
- wr_vec_done, output, 1, one-cycle pulse: the accepted write completed a vector (write-side chunk index wrapped C-1 -> 0).
- overflow, output, 1, sticky: a write was dropped.
- underflow, output, 1, sticky: a read was dropped.

Behaviour:
- Reset: rst_in high forces all of the following immediately, regardless of clock:
  - wr_ptr, rd_ptr, count and the write-side chunk index go to 0.
  - rd_data goes to 0; rd_valid, wr_vec_done, overflow, underflow go to 0.
  - Resulting flags: empty=1, full=0, vec_ready=0.
- Storage contents are not reset.
- Reset mid-vector discards all buffered chunks, including any partial vector.
- The first cycle after reset deassertion behaves as fresh.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc).
  - A write in the same cycle as a read while full is accepted.
  - On acceptance: mem[wr_ptr] <= wr_data.
  - wr_ptr advances by 1 and wraps E-1 -> 0.
- Read acceptance: rd_acc = rd_en && !empty.
  - A read and write in the same cycle while empty: the read is rejected. There is no fall-through.
  - On acceptance: rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - rd_ptr advances by 1 and wraps E-1 -> 0.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is exactly 1 cycle.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- full, empty, vec_ready and chunk_count are combinational from count and reflect the registered count. They are not bypassed by the current cycle's requests.
- Write-side chunk index:
  - Increments on wr_acc and wraps C-1 -> 0.
  - wr_vec_done is registered high for exactly one cycle after the accepted write whose index was C-1.
  - The index does not move on dropped writes.
- Partial last chunk (VecLength not a multiple of WorkingRegs): it is stored whole. Padding lanes pass through untouched; the buffer does not interpret them.
- Error flags:
  - overflow sets when wr_en && !wr_acc.
  - underflow sets when rd_en && !rd_acc.
  - Both clear only on reset.
  - Dropped operations change no pointer, count or data.
- No internal state machine beyond pointer/count tracking. Consumers gate reads on vec_ready to read whole vectors.

Test Plan:
- Default params (C=4, E=8).
- Reset, then write chunks 0x01..0x04 on 4 cycles (lane i = chunk + i):
  - wr_vec_done pulses once, the cycle after the 4th write.
  - vec_ready=1, chunk_count=4.
- Issue rd_en for 4 cycles:
  - rd_valid high on cycles 2-5.
  - rd_data chunks come out in the order 0x01..0x04.
  - empty=1 and vec_ready=0 afterward.
- Write 8 chunks, assert full=1, then write a 9th (0xFF):
  - overflow=1; chunk_count stays 8.
  - Subsequent 8 reads return the first 8 chunks; 0xFF never appears.
- When full, simultaneous wr_en (0xAA) and rd_en:
  - Both accepted; count stays 8.
  - 0xAA is read out 8th.
  - Pointers wrap correctly through 7 -> 0.
- When empty, simultaneous wr_en (0x55) and rd_en:
  - Read rejected: underflow=1, rd_valid=0.
  - count=1, and the next read returns 0x55.
- Write 2 chunks, assert rst_in asynchronously mid-cycle:
  - Outputs clear before the next edge: empty=1, rd_valid=0.
  - A following 4-chunk write produces wr_vec_done on its 4th write, not its 2nd.

Source files
------------

// File: rtl/v_chunk_fifo.sv
// v_chunk_fifo
//   Chunk-granular FIFO between vector ops. Each entry holds one
//   WorkingRegs-wide chunk. Capacity is DepthVecs whole vectors of
//   C = ceil(VecLength/WorkingRegs) chunks.
//   The last chunk of a vector may be partial. It is stored whole, and its
//   padding lanes pass through untouched.
//
// Ports
//   clk_in       : clock, rising edge
//   rst_in       : asynchronous active-high reset
//   wr_en/wr_data: push one chunk (dropped when full, unless a read is also accepted)
//   rd_en        : pop one chunk (dropped when empty; no fall-through)
//   rd_data      : registered chunk popped on the previous cycle
//   rd_valid     : rd_data was updated by a pop on the previous cycle
//   vec_ready    : at least one whole vector is buffered
//   full/empty   : registered-count status
//   chunk_count  : number of stored chunks
//   wr_vec_done  : one-cycle pulse after the write that completed a vector
//   overflow     : sticky, a write was dropped
//   underflow    : sticky, a read was dropped
module v_chunk_fifo #(
  parameter  int VecLength   = 16,
  parameter  int NBits       = 8,
  parameter  int WorkingRegs = 4,
  parameter  int DepthVecs   = 2,
  localparam int C   = (VecLength + WorkingRegs - 1) / WorkingRegs,
  localparam int E   = DepthVecs * C,
  localparam int PW  = (E > 1) ? $clog2(E) : 1,
  localparam int CW  = $clog2(E + 1),
  localparam int IW  = (C > 1) ? $clog2(C) : 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 wr_en,
  input  logic signed [WorkingRegs-1:0][NBits-1:0] wr_data,
  input  logic                                 rd_en,
  output logic signed [WorkingRegs-1:0][NBits-1:0] rd_data,
  output logic                                 rd_valid,
  output logic                                 vec_ready,
  output logic                                 full,
  output logic                                 empty,
  output logic [CW-1:0]                        chunk_count,
  output logic                                 wr_vec_done,
  output logic                                 overflow,
  output logic                                 underflow
);

  logic [WorkingRegs-1:0][NBits-1:0] r_mem [E];

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_chunk_idx;
  logic [WorkingRegs-1:0][NBits-1:0] r_rd_data;
  logic          r_rd_valid, r_wr_vec_done, r_overflow, r_underflow;

  logic w_full, w_empty, w_wr_acc, w_rd_acc;

  // Flags come from the registered count only; same-cycle requests never bypass them.
  assign w_full  = (r_count == CW'(E));
  assign w_empty = (r_count == '0);

  // A read frees the slot this cycle, so a write into a full buffer is accepted alongside it.
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  // Storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_chunk_idx   <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_wr_vec_done <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr    <= (r_wr_ptr == PW'(E - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_chunk_idx <= (r_chunk_idx == IW'(C - 1)) ? '0 : r_chunk_idx + 1'b1;
      end
      r_wr_vec_done <= w_wr_acc && (r_chunk_idx == IW'(C - 1));

      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= (r_rd_ptr == PW'(E - 1)) ? '0 : r_rd_ptr + 1'b1;
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign vec_ready   = (r_count >= CW'(C));
  assign full        = w_full;
  assign empty       = w_empty;
  assign chunk_count = r_count;
  assign wr_vec_done = r_wr_vec_done;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_v_chunk_fifo.sv
module tb_v_chunk_fifo;
  localparam int VL = 16, NB = 8, WR = 4, DV = 2;
  localparam int C  = (VL + WR - 1) / WR;
  localparam int E  = DV * C;
  localparam int CW = $clog2(E + 1);

  typedef logic [WR-1:0][NB-1:0] chunk_t;

  logic          clk_in = 0, rst_in = 1;
  logic          wr_en = 0, rd_en = 0;
  chunk_t        wr_data = '0;
  chunk_t        rd_data;
  logic          rd_valid, vec_ready, full, empty, wr_vec_done, overflow, underflow;
  logic [CW-1:0] chunk_count;

  v_chunk_fifo #(.VecLength(VL), .NBits(NB), .WorkingRegs(WR), .DepthVecs(DV)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .vec_ready(vec_ready), .full(full), .empty(empty),
    .chunk_count(chunk_count), .wr_vec_done(wr_vec_done),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;

  // Reference model: a queue of stored chunks plus simple counters.
  chunk_t m_q[$];
  chunk_t sb_q[$];     // expected read data, consumed by the monitor
  int     n_wr = 0;    // accepted writes since reset
  bit     m_valid = 0, m_vd = 0, m_ovf = 0, m_udf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic chunk_t mk(input int c);
    chunk_t r;
    for (int i = 0; i < WR; i++) r[i] = NB'(c + i);
    return r;
  endfunction

  // Monitor: every presented read is popped from the scoreboard and compared.
  always @(negedge clk_in) begin
    if (!rst_in && rd_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data, $time);
      end else begin
        chunk_t e;
        e = sb_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  task automatic check_flags(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"},     chunk_count, n);
    chk({tag, ".empty"},     empty,       n == 0);
    chk({tag, ".full"},      full,        n == E);
    chk({tag, ".vec_ready"}, vec_ready,   n >= C);
    chk({tag, ".rd_valid"},  rd_valid,    m_valid);
    chk({tag, ".vec_done"},  wr_vec_done, m_vd);
    chk({tag, ".overflow"},  overflow,    m_ovf);
    chk({tag, ".underflow"}, underflow,   m_udf);
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic step(input bit we, input chunk_t wd, input bit re, input string tag);
    bit racc, wacc;
    wr_en = we; wr_data = wd; rd_en = re;
    racc = re && (m_q.size() != 0);
    wacc = we && (m_q.size() < E || racc);
    @(posedge clk_in);
    if (racc) sb_q.push_back(m_q.pop_front());
    if (wacc) begin
      m_q.push_back(wd);
      n_wr++;
      m_vd = (n_wr % C) == 0;
    end else m_vd = 0;
    m_valid = racc;
    if (we && !wacc) m_ovf = 1;
    if (re && !racc) m_udf = 1;
    #1;
    wr_en = 0; rd_en = 0;
    check_flags(tag);
  endtask

  task automatic model_reset();
    m_q.delete(); sb_q.delete();
    n_wr = 0; m_valid = 0; m_vd = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic do_reset();
    rst_in = 1;
    #1;
    model_reset();
    chk("rst.rd_data", rd_data, 0);
    check_flags("rst");
    @(posedge clk_in); #3;
    rst_in = 0;
    @(posedge clk_in); #1;
    check_flags("post_rst");
  endtask

  initial begin
    do_reset();

    // One vector in, pulse after the 4th write.
    for (int k = 1; k <= 4; k++) step(1, mk(k), 0, "wr_vec");
    chk("wr_vec.count4", chunk_count, 4);
    step(0, '0, 0, "idle");
    for (int k = 0; k < 4; k++) step(0, '0, 1, "rd_vec");
    step(0, '0, 0, "rd_drain");
    chk("rd_vec.empty", empty, 1);

    // Fill, overflow with 0xFF, then drain.
    for (int k = 0; k < E; k++) step(1, mk(8'h10 + k * 4), 0, "fill");
    chk("fill.full", full, 1);
    step(1, mk(8'hFF), 0, "ovf");
    chk("ovf.count8", chunk_count, E);
    for (int k = 0; k < E; k++) step(0, '0, 1, "drain");
    step(0, '0, 0, "drain_end");

    // Full with simultaneous read/write: 0xAA comes out 8th.
    for (int k = 0; k < E; k++) step(1, mk(8'h40 + k * 4), 0, "fill2");
    step(1, mk(8'hAA), 1, "full_rw");
    chk("full_rw.count8", chunk_count, E);
    for (int k = 0; k < E; k++) step(0, '0, 1, "drain2");
    step(0, '0, 0, "drain2_end");

    // Empty with simultaneous read/write: read rejected, 0x55 stored.
    step(1, mk(8'h55), 1, "empty_rw");
    chk("empty_rw.underflow", underflow, 1);
    chk("empty_rw.rd_valid", rd_valid, 0);
    step(0, '0, 1, "rd55");
    step(0, '0, 0, "rd55_end");

    // Asynchronous reset in the middle of a cycle with a partial vector.
    do_reset();
    step(1, mk(8'h60), 0, "part");
    step(1, mk(8'h64), 1, "part");
    #2 rst_in = 1;
    #1;
    chk("async.empty", empty, 1);
    chk("async.rd_valid", rd_valid, 0);
    chk("async.count", chunk_count, 0);
    model_reset();
    @(posedge clk_in); #3;
    rst_in = 0;
    #2;
    for (int k = 0; k < 4; k++) step(1, mk(8'h70 + k * 4), 0, "after_rst");

    // Randomized traffic against the queue model.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 99) < 55, chunk_t'($urandom), $urandom_range(0, 99) < 50, "rand");
    for (int k = 0; k < E + 1; k++) step(0, '0, 1, "final_drain");
    step(0, '0, 0, "final");
    @(negedge clk_in);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
